xnor_response_checker: RTL and testbench
========================================

// Module: xnor_response_checker
// PURPOSE
//  Hardware response checker for the 3-input XNOR cell: sweeps all 8 input
//  vectors (000..111) onto the DUT, waits a settle window, samples dut_result,
//  compares against ~(a^b^c), counts mismatches and reports pass/fail.
//  Sits beside simple_xnor on the lab board; it is the checking end of the
//  stimulus/response path.
// PARAMETERS
//  SETTLE_CYCLES  4  clk cycles between driving a vector and sampling (>=1)
//  ERR_W          4  width of err_count; count saturates at 2**ERR_W-1
// PORTS
//  clk              in   1      rising-edge clock
//  rst_n            in   1      async active-low reset
//  start            in   1      1-cycle pulse; begins sweep when not busy
//  dut_a            out  1      DUT input a (vector bit 2)
//  dut_b            out  1      DUT input b (vector bit 1)
//  dut_c            out  1      DUT input c (vector bit 0)
//  dut_result       in   1      DUT output under test
//  busy             out  1      high from sweep start until DONE
//  done             out  1      sticky high after sweep; cleared by next start
//  pass             out  1      valid when done: 1 iff err_count==0
//  err_count        out  ERR_W  mismatches in current/last sweep
//  first_err_valid  out  1      a mismatch has been captured this sweep
//  first_err_vec    out  3      {a,b,c} of first mismatching vector
// BEHAVIOUR
//  - Reset (async, rst_n=0): state IDLE; dut_a/b/c=0, busy=0, done=0, pass=0,
//    err_count=0, first_err_valid=0, first_err_vec=0, vec=0, settle cnt=0.
//  - FSM: IDLE -> DRIVE -> SETTLE -> SAMPLE -> (DRIVE | DONE); DONE -> DRIVE.
//  - IDLE/DONE: start=1 -> DRIVE; clears done, pass, err_count,
//    first_err_valid, first_err_vec; vec=0; busy=1 next cycle.
//  - DRIVE (1 cycle): {dut_a,dut_b,dut_c} <= vec (registered); cnt=0.
//  - SETTLE: cnt increments each cycle; exits to SAMPLE after SETTLE_CYCLES.
//  - SAMPLE (1 cycle): expected = ~(dut_a^dut_b^dut_c); on mismatch
//    err_count+1 (saturating), and if !first_err_valid capture vec into
//    first_err_vec, set first_err_valid. vec==7 -> DONE, else vec+1 -> DRIVE.
//  - Per vector: SETTLE_CYCLES+2 cycles; full sweep 8*(SETTLE_CYCLES+2)
//    cycles from start to done rising (SETTLE_CYCLES=4 -> 48 cycles).
//  - DONE: busy=0, done=1, pass=(err_count==0); DUT inputs hold 111.
//  - start while busy: ignored, no restart, no effect on counters.
//  - dut_result X/Z at sample: counts as mismatch (compare with !==).
//  - vec is 3 bits; increment only in SAMPLE with vec<7, never wraps.
//  - err_count saturates: at all-ones further mismatches leave it unchanged.
//  - rst_n low mid-sweep: immediate return to reset values; no done pulse.
// CONFIGURATION
//  XNOR_CHK_STOP_ON_ERR_EN
//  - defined: first mismatch in SAMPLE goes straight to DONE (pass=0,
//    err_count=1, first_err_vec=failing vector); remaining vectors skipped.
//  - undefined: all 8 vectors always checked; err_count = total mismatches.
// TESTING
//  1 Correct XNOR DUT, start pulse -> done at cycle 48, pass=1, err_count=0,
//    first_err_valid=0, DUT inputs stepped 000..111 in order.
//  2 DUT = 3-input XOR -> pass=0, err_count=8, first_err_vec=000;
//    with XNOR_CHK_STOP_ON_ERR_EN -> err_count=1, done after 6 cycles.
//  3 DUT stuck-at-1 -> mismatches on 001,010,100,111: err_count=4,
//    first_err_vec=001.
//  4 ERR_W=2, XOR DUT -> err_count saturates at 3, pass=0.
//  5 start re-pulsed at cycle 20 -> ignored, done still at cycle 48;
//    start in DONE -> done clears, new sweep completes 48 cycles later.
//  6 rst_n low at cycle 25 -> all outputs 0 at once; no done; fresh start
//    after release gives normal 48-cycle sweep.

Source files
------------

// File: rtl/xnor_response_checker.sv
// xnor_response_checker: sweeps all 8 input vectors onto a 3-input XNOR cell,
// waits a settle window, samples its result and counts mismatches.
// Optional build macro XNOR_CHK_STOP_ON_ERR_EN: stop the sweep at the first
// mismatch instead of checking all 8 vectors.
module xnor_response_checker #(
  parameter int unsigned SETTLE_CYCLES = 4,
  parameter int unsigned ERR_W         = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic             dut_a,
  output logic             dut_b,
  output logic             dut_c,
  input  logic             dut_result,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_count,
  output logic             first_err_valid,
  output logic [2:0]       first_err_vec
);

  localparam int unsigned CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE_CYCLES - 1);

`ifdef XNOR_CHK_STOP_ON_ERR_EN
  localparam bit STOP_ON_ERR = 1'b1;
`else
  localparam bit STOP_ON_ERR = 1'b0;
`endif

  typedef enum logic [2:0] {
    S_IDLE,
    S_DRIVE,
    S_SETTLE,
    S_SAMPLE,
    S_DONE
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [2:0]       r_vec;
  logic [CNT_W-1:0] r_cnt;
  logic             w_expected;
  logic             w_mismatch;
  logic             w_last;
  logic [ERR_W-1:0] w_err_nxt;

  // Compare against the registered vector actually driven onto the DUT;
  // X/Z on the result counts as a mismatch.
  always_comb begin
    w_expected = ~(dut_a ^ dut_b ^ dut_c);
    w_mismatch = (dut_result !== w_expected);
    w_last     = (r_vec == 3'd7) || (STOP_ON_ERR && w_mismatch);
    w_err_nxt  = err_count;
    if (w_mismatch && (err_count != '1)) begin
      w_err_nxt = err_count + ERR_W'(1);
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE, S_DONE: if (start) w_state_nxt = S_DRIVE;
      S_DRIVE:        w_state_nxt = S_SETTLE;
      S_SETTLE:       if (r_cnt == CNT_LAST) w_state_nxt = S_SAMPLE;
      S_SAMPLE:       w_state_nxt = w_last ? S_DONE : S_DRIVE;
      default:        w_state_nxt = S_IDLE;
    endcase
  end

  // Datapath: vector, settle counter, DUT drive, results and status flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vec           <= '0;
      r_cnt           <= '0;
      dut_a           <= 1'b0;
      dut_b           <= 1'b0;
      dut_c           <= 1'b0;
      busy            <= 1'b0;
      done            <= 1'b0;
      pass            <= 1'b0;
      err_count       <= '0;
      first_err_valid <= 1'b0;
      first_err_vec   <= '0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (start) begin
            r_vec           <= '0;
            busy            <= 1'b1;
            done            <= 1'b0;
            pass            <= 1'b0;
            err_count       <= '0;
            first_err_valid <= 1'b0;
            first_err_vec   <= '0;
          end
        end
        S_DRIVE: begin
          {dut_a, dut_b, dut_c} <= r_vec;
          r_cnt                 <= '0;
        end
        S_SETTLE: begin
          r_cnt <= r_cnt + CNT_W'(1);
        end
        S_SAMPLE: begin
          err_count <= w_err_nxt;
          if (w_mismatch && !first_err_valid) begin
            first_err_valid <= 1'b1;
            first_err_vec   <= r_vec;
          end
          if (w_last) begin
            busy <= 1'b0;
            done <= 1'b1;
            pass <= (w_err_nxt == '0);
          end else begin
            r_vec <= r_vec + 3'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_xnor_response_checker.sv
// Directed bench for xnor_response_checker: behavioural DUT models (XNOR,
// XOR, stuck-at-1) plus a second instance with ERR_W=2 against an XOR cell.
module tb_xnor_response_checker;

  localparam int unsigned SC  = 4;
  localparam int unsigned PER = SC + 2;
  localparam int unsigned SWP = 8 * PER;

  localparam int M_XNOR = 0;
  localparam int M_XOR  = 1;
  localparam int M_ST1  = 2;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic       dut_a, dut_b, dut_c, dut_result;
  logic       busy, done, pass, fev;
  logic [3:0] err;
  logic [2:0] fvec;
  int         mode;

  logic       a2, b2, c2, res2;
  logic       busy2, done2, pass2, fev2;
  logic [1:0] err2;
  logic [2:0] fvec2;

  int n_vec = 0;
  int n_err = 0;
  int cyc;

  always #5 clk = ~clk;

  always_comb begin
    case (mode)
      M_XOR:   dut_result = dut_a ^ dut_b ^ dut_c;
      M_ST1:   dut_result = 1'b1;
      default: dut_result = ~(dut_a ^ dut_b ^ dut_c);
    endcase
  end

  assign res2 = a2 ^ b2 ^ c2;

  xnor_response_checker #(.SETTLE_CYCLES(SC), .ERR_W(4)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .dut_a(dut_a), .dut_b(dut_b), .dut_c(dut_c), .dut_result(dut_result),
    .busy(busy), .done(done), .pass(pass), .err_count(err),
    .first_err_valid(fev), .first_err_vec(fvec)
  );

  xnor_response_checker #(.SETTLE_CYCLES(SC), .ERR_W(2)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .start(start),
    .dut_a(a2), .dut_b(b2), .dut_c(c2), .dut_result(res2),
    .busy(busy2), .done(done2), .pass(pass2), .err_count(err2),
    .first_err_valid(fev2), .first_err_vec(fvec2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_cleared(input string tag);
    chk({tag, "_abc"},  {dut_a, dut_b, dut_c}, 3'b000);
    chk({tag, "_busy"}, busy, 1'b0);
    chk({tag, "_done"}, done, 1'b0);
    chk({tag, "_pass"}, pass, 1'b0);
    chk({tag, "_err"},  err,  4'd0);
    chk({tag, "_fev"},  fev,  1'b0);
    chk({tag, "_fvec"}, fvec, 3'd0);
  endtask

  // Start is sampled on the posedge between the two negedges.
  task automatic pulse_start();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
  endtask

  // Returns edges elapsed since the start edge when done is first seen.
  task automatic run_sweep(input int pulse_at, input int abort_at,
                           input bit chk_vec, output int cycles);
    cycles = 0;
    while (cycles < 200) begin
      if (done) break;
      if (chk_vec && cycles >= 1 && ((cycles - 1) % PER) == 0)
        chk($sformatf("vec@%0d", cycles), {dut_a, dut_b, dut_c}, (cycles - 1) / PER);
      if (chk_vec && cycles == 10) chk("busy_mid", busy, 1'b1);
      if (cycles == pulse_at)     start = 1'b1;
      if (cycles == pulse_at + 1) start = 1'b0;
      if (cycles == abort_at) begin
        chk("busy_pre_abort", busy, 1'b1);
        rst_n = 1'b0;
        #1;
        return;
      end
      @(negedge clk);
      cycles++;
    end
    chk("done_seen", done, 1'b1);
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    mode  = M_XNOR;
    repeat (3) @(negedge clk);
    chk_cleared("rst");
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_busy", busy, 1'b0);

    // 1: correct XNOR cell
    pulse_start();
    chk("t1_busy", busy, 1'b1);
    run_sweep(-1, -1, 1'b1, cyc);
    chk("t1_cycles", cyc, SWP);
    chk("t1_pass", pass, 1'b1);
    chk("t1_err", err, 4'd0);
    chk("t1_fev", fev, 1'b0);
    chk("t1_busy_end", busy, 1'b0);
    chk("t1_hold", {dut_a, dut_b, dut_c}, 3'b111);

    // 4: ERR_W=2 against XOR saturates
`ifdef XNOR_CHK_STOP_ON_ERR_EN
    chk("t4_err2", err2, 2'd1);
`else
    chk("t4_err2", err2, 2'd3);
`endif
    chk("t4_pass2", pass2, 1'b0);
    chk("t4_done2", done2, 1'b1);

    // 2: XOR cell, restart from DONE clears done
    mode = M_XOR;
    pulse_start();
    chk("t2_done_clr", done, 1'b0);
    chk("t2_busy", busy, 1'b1);
    run_sweep(-1, -1, 1'b0, cyc);
`ifdef XNOR_CHK_STOP_ON_ERR_EN
    chk("t2_cycles", cyc, PER);
    chk("t2_err", err, 4'd1);
`else
    chk("t2_cycles", cyc, SWP);
    chk("t2_err", err, 4'd8);
`endif
    chk("t2_pass", pass, 1'b0);
    chk("t2_fev", fev, 1'b1);
    chk("t2_fvec", fvec, 3'd0);

    // 3: stuck-at-1 fails on odd-parity vectors
    mode = M_ST1;
    pulse_start();
    run_sweep(-1, -1, 1'b0, cyc);
`ifdef XNOR_CHK_STOP_ON_ERR_EN
    chk("t3_err", err, 4'd1);
`else
    chk("t3_err", err, 4'd4);
`endif
    chk("t3_fvec", fvec, 3'd1);
    chk("t3_fev", fev, 1'b1);
    chk("t3_pass", pass, 1'b0);

    // 5: start while busy is ignored
    mode = M_XNOR;
    pulse_start();
    run_sweep(20, -1, 1'b1, cyc);
    chk("t5_cycles", cyc, SWP);
    chk("t5_pass", pass, 1'b1);
    chk("t5_err", err, 4'd0);

    // 6: reset mid-sweep, then a fresh sweep
    pulse_start();
    run_sweep(-1, 25, 1'b0, cyc);
    chk_cleared("abort");
    repeat (3) @(negedge clk);
    chk("abort_nodone", done, 1'b0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("abort_idle", busy, 1'b0);
    pulse_start();
    run_sweep(-1, -1, 1'b1, cyc);
    chk("t6_cycles", cyc, SWP);
    chk("t6_pass", pass, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
